// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - CPU-side blocking initiator for the 8-bit-address debug IO bus
module io_bus_master #(
    parameter logic [7:0]  IN_DATA  = 8'h10,
    parameter logic [7:0]  IN_STAT  = 8'h14,
    parameter logic [7:0]  OUT_DATA = 8'h08,
    parameter logic [7:0]  OUT_STAT = 8'h0C,
    parameter bit          POLL_EN  = 1'b1,
    parameter int unsigned POLL_MAX = 0
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req,
    input  logic        req_we,
    input  logic [7:0]  req_addr,
    input  logic [31:0] req_wdata,
    output logic        busy,
    output logic        resp_done,
    output logic        resp_err,
    output logic [31:0] resp_rdata,
    output logic [7:0]  io_addr,
    output logic [31:0] io_dout,
    output logic        io_we,
    output logic        io_rd,
    input  logic [31:0] io_din
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRD,
        S_PCAP,
        S_WR,
        S_RD,
        S_RCAP,
        S_FIN
    } state_t;

    localparam logic [15:0] POLL_LIMIT = 16'(POLL_MAX);

    state_t      state_q, state_d;
    logic        we_q, we_d;
    logic [7:0]  addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [15:0] poll_cnt_q, poll_cnt_d;
    logic [15:0] poll_inc;
    logic        busy_q, busy_d;
    logic        resp_done_q, resp_done_d;
    logic        resp_err_q, resp_err_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic [7:0]  io_addr_q, io_addr_d;
    logic [31:0] io_dout_q, io_dout_d;
    logic        io_we_q, io_we_d;
    logic        io_rd_q, io_rd_d;

    // Next-state logic; every output is computed from the state being entered so it is registered
    always_comb begin
        state_d      = state_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        poll_cnt_d   = poll_cnt_q;
        resp_rdata_d = resp_rdata_q;
        io_addr_d    = io_addr_q;
        io_dout_d    = io_dout_q;
        resp_done_d  = 1'b0;
        resp_err_d   = 1'b0;
        io_we_d      = 1'b0;
        io_rd_d      = 1'b0;
        poll_inc     = (poll_cnt_q == 16'hFFFF) ? poll_cnt_q : poll_cnt_q + 16'd1;

        case (state_q)
            S_IDLE: begin
                if (req) begin
                    we_d       = req_we;
                    addr_d     = req_addr;
                    wdata_d    = req_wdata;
                    err_d      = 1'b0;
                    poll_cnt_d = 16'd0;
                    if (req_addr[1:0] != 2'b00) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else if (POLL_EN && !req_we && req_addr == IN_DATA) begin
                        io_addr_d = IN_STAT;
                        state_d   = S_PRD;
                    end else if (POLL_EN && req_we && req_addr == OUT_DATA) begin
                        io_addr_d = OUT_STAT;
                        state_d   = S_PRD;
                    end else begin
                        io_addr_d = req_addr;
                        state_d   = req_we ? S_WR : S_RD;
                    end
                end
            end
            S_PRD: begin
                state_d = S_PCAP;
            end
            S_PCAP: begin
                if (io_din != 32'd0) begin
                    poll_cnt_d = poll_inc;
                    if (POLL_LIMIT != 16'd0 && poll_inc == POLL_LIMIT) begin
                        err_d   = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        state_d = S_PRD;
                    end
                end else begin
                    io_addr_d = addr_q;
                    state_d   = we_q ? S_WR : S_RD;
                end
            end
            S_WR: begin
                state_d = S_FIN;
            end
            S_RD: begin
                state_d = S_RCAP;
            end
            S_RCAP: begin
                resp_rdata_d = io_din;
                state_d      = S_FIN;
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Strobes and completion flags belong to the cycle spent in the state just entered
        if (state_d == S_PRD || state_d == S_RD) begin
            io_rd_d = 1'b1;
        end
        if (state_d == S_WR) begin
            io_we_d   = 1'b1;
            io_dout_d = wdata_d;
        end
        if (state_d == S_FIN) begin
            resp_done_d = 1'b1;
            resp_err_d  = err_d;
            if (err_d && !we_d) begin
                resp_rdata_d = 32'd0;
            end
        end
        busy_d = (state_d != S_IDLE) && (state_d != S_FIN);
    end

    // State and output registers; reset drops any transaction in flight without a done pulse
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            we_q         <= 1'b0;
            addr_q       <= 8'd0;
            wdata_q      <= 32'd0;
            err_q        <= 1'b0;
            poll_cnt_q   <= 16'd0;
            busy_q       <= 1'b0;
            resp_done_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= 32'd0;
            io_addr_q    <= 8'd0;
            io_dout_q    <= 32'd0;
            io_we_q      <= 1'b0;
            io_rd_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            poll_cnt_q   <= poll_cnt_d;
            busy_q       <= busy_d;
            resp_done_q  <= resp_done_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            io_addr_q    <= io_addr_d;
            io_dout_q    <= io_dout_d;
            io_we_q      <= io_we_d;
            io_rd_q      <= io_rd_d;
        end
    end

    assign busy       = busy_q;
    assign resp_done  = resp_done_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign io_addr    = io_addr_q;
    assign io_dout    = io_dout_q;
    assign io_we      = io_we_q;
    assign io_rd      = io_rd_q;

endmodule

// File: tb/tb_io_bus_master.sv
// tb/tb_io_bus_master.sv - directed self-checking bench for io_bus_master
module tb_io_bus_master;

    logic        clk = 1'b0;
    logic        rstn;
    logic        req;
    logic        req_we;
    logic [7:0]  req_addr;
    logic [31:0] req_wdata;
    logic        busy;
    logic        resp_done;
    logic        resp_err;
    logic [31:0] resp_rdata;
    logic [7:0]  io_addr;
    logic [31:0] io_dout;
    logic        io_we;
    logic        io_rd;
    logic [31:0] io_din = 32'd0;

    int n_checks = 0;
    int n_fail   = 0;

    // responder configuration and per-transaction observations
    int          out_busy_n = 0;
    int          in_busy_n  = 0;
    logic [31:0] rd_val     = 32'd0;
    int          stat_reads;
    int          rd_tgt;
    int          we_cnt;
    int          both_cnt;
    int          first_we;
    int          done_n;
    logic        done_err;
    logic [7:0]  last_we_addr;
    logic [31:0] last_dout;
    logic        aborted;

    io_bus_master #(
        .POLL_MAX(4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .busy       (busy),
        .resp_done  (resp_done),
        .resp_err   (resp_err),
        .resp_rdata (resp_rdata),
        .io_addr    (io_addr),
        .io_dout    (io_dout),
        .io_we      (io_we),
        .io_rd      (io_rd),
        .io_din     (io_din)
    );

    always #5 clk = ~clk;

    // Responder: data registered on the io_rd edge; status reads report busy for a set number of polls
    always @(posedge clk) begin
        if (io_rd) begin
            if (io_addr == 8'h0C)
                io_din <= (stat_reads <= out_busy_n) ? 32'd1 : 32'd0;
            else if (io_addr == 8'h14)
                io_din <= (stat_reads <= in_busy_n) ? 32'd1 : 32'd0;
            else
                io_din <= rd_val;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request, watch the bus each cycle, stop at resp_done or at the abort cycle
    task automatic run(input logic we, input logic [7:0] addr, input logic [31:0] wd,
                       input int pulse_at, input int abort_at);
        int n;
        stat_reads   = 0;
        rd_tgt       = 0;
        we_cnt       = 0;
        both_cnt     = 0;
        first_we     = 0;
        done_n       = 0;
        done_err     = 1'b0;
        last_we_addr = 8'd0;
        last_dout    = 32'd0;
        aborted      = 1'b0;
        @(negedge clk);
        req       = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wd;
        @(posedge clk);
        n = 0;
        while (done_n == 0 && !aborted && n < 40) begin
            @(negedge clk);
            n++;
            if (n == 1) req = 1'b0;
            if (pulse_at != 0 && n == pulse_at) begin
                req      = 1'b1;
                req_we   = 1'b1;
                req_addr = 8'h00;
            end
            if (pulse_at != 0 && n == pulse_at + 1) req = 1'b0;
            if (io_we && io_rd) both_cnt++;
            if (io_we) begin
                we_cnt++;
                last_we_addr = io_addr;
                last_dout    = io_dout;
                if (first_we == 0) first_we = n;
            end
            if (io_rd) begin
                if (io_addr == 8'h0C || io_addr == 8'h14) stat_reads++;
                else rd_tgt++;
            end
            if (abort_at != 0 && n == abort_at) begin
                rstn = 1'b0;
                #1;
                aborted = 1'b1;
            end else if (resp_done) begin
                done_n   = n;
                done_err = resp_err;
            end
        end
        if (!aborted && done_n == 0) check("timeout_no_done", 32'd0, 32'd1);
    endtask

    initial begin
        rstn      = 1'b0;
        req       = 1'b0;
        req_we    = 1'b0;
        req_addr  = 8'd0;
        req_wdata = 32'd0;
        repeat (3) @(negedge clk);
        check("rst_busy",  {31'd0, busy},      32'd0);
        check("rst_done",  {31'd0, resp_done}, 32'd0);
        check("rst_err",   {31'd0, resp_err},  32'd0);
        check("rst_rdata", resp_rdata,         32'd0);
        check("rst_addr",  {24'd0, io_addr},   32'd0);
        check("rst_dout",  io_dout,            32'd0);
        check("rst_we",    {31'd0, io_we},     32'd0);
        check("rst_rd",    {31'd0, io_rd},     32'd0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // direct write
        run(1'b1, 8'h00, 32'h0000_1234, 0, 0);
        check("t1_done_cyc", done_n,             32'd2);
        check("t1_err",      {31'd0, done_err},  32'd0);
        check("t1_we_cnt",   we_cnt,             32'd1);
        check("t1_we_cyc",   first_we,           32'd1);
        check("t1_we_addr",  {24'd0, last_we_addr}, 32'h00);
        check("t1_dout",     last_dout,          32'h0000_1234);
        check("t1_rd_cnt",   rd_tgt + stat_reads, 32'd0);

        // direct read
        rd_val = 32'h0000_ABCD;
        run(1'b0, 8'h04, 32'd0, 0, 0);
        check("t2_done_cyc", done_n,             32'd3);
        check("t2_err",      {31'd0, done_err},  32'd0);
        check("t2_rdata",    resp_rdata,         32'h0000_ABCD);
        check("t2_rd_cnt",   rd_tgt,             32'd1);
        check("t2_we_cnt",   we_cnt,             32'd0);
        @(negedge clk);
        check("t2_rdata_hold", resp_rdata,       32'h0000_ABCD);

        // polled write with three busy polls, plus a req pulse while busy
        out_busy_n = 3;
        run(1'b1, 8'h08, 32'hDEAD_BEEF, 3, 0);
        check("t3_polls",    stat_reads,         32'd4);
        check("t3_done_cyc", done_n,             32'd10);
        check("t3_err",      {31'd0, done_err},  32'd0);
        check("t3_we_cnt",   we_cnt,             32'd1);
        check("t3_we_cyc",   first_we,           32'd9);
        check("t3_we_addr",  {24'd0, last_we_addr}, 32'h08);
        check("t3_dout",     last_dout,          32'hDEAD_BEEF);
        check("t3_both",     both_cnt,           32'd0);
        repeat (4) @(negedge clk);
        check("t3_no_extra_busy", {31'd0, busy}, 32'd0);
        check("t3_no_extra_we",   {31'd0, io_we}, 32'd0);

        // polled read hitting the poll limit
        in_busy_n = 1000;
        run(1'b0, 8'h10, 32'd0, 0, 0);
        check("t4_polls",    stat_reads,         32'd4);
        check("t4_done_cyc", done_n,             32'd9);
        check("t4_err",      {31'd0, done_err},  32'd1);
        check("t4_rd_data",  rd_tgt,             32'd0);
        check("t4_rdata",    resp_rdata,         32'd0);

        // misaligned access
        run(1'b0, 8'h05, 32'd0, 0, 0);
        check("t5_done_cyc", done_n,             32'd1);
        check("t5_err",      {31'd0, done_err},  32'd1);
        check("t5_bus",      we_cnt + rd_tgt + stat_reads, 32'd0);

        // reset asserted during the first status capture
        run(1'b0, 8'h10, 32'd0, 0, 2);
        check("t6_aborted",  {31'd0, aborted},   32'd1);
        check("t6_rd",       {31'd0, io_rd},     32'd0);
        check("t6_busy",     {31'd0, busy},      32'd0);
        check("t6_done",     {31'd0, resp_done}, 32'd0);
        check("t6_addr",     {24'd0, io_addr},   32'd0);
        repeat (2) @(negedge clk);
        check("t6_done_held", {31'd0, resp_done}, 32'd0);
        rstn = 1'b1;
        @(negedge clk);
        run(1'b1, 8'h00, 32'h0000_5A5A, 0, 0);
        check("t6_post_done_cyc", done_n,        32'd2);
        check("t6_post_err",  {31'd0, done_err}, 32'd0);
        check("t6_post_dout", last_dout,         32'h0000_5A5A);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
